mdu_seq: RTL

- Iterative multiply/divide sequencer for the MIPS datapath.
- Implements MULTU/DIVU by borrowing the shared 32-bit ALU for one add or subtract per cycle over 32 iterations.
- Owns the HI/LO registers.
- Sits beside the ALU. While `alu_req_o` is high, the top level muxes this block's `alu_src1_o`/`alu_src2_o`/`alu_ctrl_o` onto the ALU inputs in place of the decoder's.

---
 rtl/mdu_seq.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq -- iterative multiply/divide sequencer with HI/LO ownership
//
// Runs MULTU (shift-add) and DIVU (restoring shift-subtract) over ITER cycles.
// Each cycle it borrows the shared 32-bit datapath ALU for one add or
// subtract. While alu_req_o is high the top level must route alu_src1_o,
// alu_src2_o and alu_ctrl_o onto the ALU in place of the decoder's operands.
// The ALU's answer comes back on alu_result_i in the same cycle.
//
// Build option:
//   MDU_SIGNED_EN  When defined, op_i[1]=1 selects signed MULT/DIV. Operands
//                  are made positive on accept. A FIX state then applies the
//                  result signs and costs one extra cycle. When undefined,
//                  op_i[1] is ignored and every operation is unsigned.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         synchronous active-low reset
//   start_i       request, accepted only in IDLE
//   op_i[1:0]     bit0: 0=multiply 1=divide; bit1: signed (MDU_SIGNED_EN)
//   rs_i, rt_i    multiplicand/dividend, multiplier/divisor
//   alu_result_i  result from the shared ALU
//   alu_req_o     block owns the ALU this cycle
//   alu_src1_o    ALU operand 1 (0 when the ALU is not owned)
//   alu_src2_o    ALU operand 2 (0 when the ALU is not owned)
//   alu_ctrl_o    ALU operation: 2=add, 3=sub (0 when the ALU is not owned)
//   busy_o        operation in flight (MUL/DIV/FIX/DONE)
//   done_o        one-cycle completion pulse
//   div0_o        last divide had a zero divisor; held until the next accept
//   hi_o, lo_o    HI/LO registers (product hi:lo, or remainder:quotient)
// -----------------------------------------------------------------------------
module mdu_seq #(
    parameter int ITER = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] alu_result_i,
    output logic        alu_req_o,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        div0_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int              CNT_W   = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
`ifdef MDU_SIGNED_EN
        S_FIX,
`endif
        S_DONE
    } state_t;

    state_t           r_state;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_mcand;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;
    logic             r_alu_req;

`ifdef MDU_SIGNED_EN
    logic             r_signed;
    logic             r_is_div;
    logic             r_neg_rs;
    logic             r_neg_rt;
`endif

    // Operand values captured on accept (absolute values for signed ops).
    logic [31:0] w_acc_rs;
    logic [31:0] w_acc_rt;

`ifdef MDU_SIGNED_EN
    logic        w_neg_rs;
    logic        w_neg_rt;

    assign w_neg_rs = op_i[1] & rs_i[31];
    assign w_neg_rt = op_i[1] & rt_i[31];
    assign w_acc_rs = w_neg_rs ? (32'd0 - rs_i) : rs_i;
    assign w_acc_rt = w_neg_rt ? (32'd0 - rt_i) : rt_i;
`else
    // op_i[1] only has meaning in the signed build.
    logic        w_unused_op_signed;

    assign w_unused_op_signed = op_i[1];
    assign w_acc_rs = rs_i;
    assign w_acc_rt = rt_i;
`endif

    // Divide step: partial remainder shifted left, with the next dividend bit
    // pulled in from the top of LO.
    logic [31:0] w_div_src1;
    logic        w_div_ge;
    logic        w_mul_carry;

    assign w_div_src1 = {r_hi[30:0], r_lo[31]};
    // With hi[31] set, the shifted remainder is 33 bits wide and so is always
    // >= the divisor. The truncated 32-bit ALU difference is still correct.
    assign w_div_ge    = r_hi[31] | (w_div_src1 >= r_mcand);
    // The ALU adder has no carry-out, so the carry is recovered by detecting wrap.
    assign w_mul_carry = (alu_result_i < r_hi);

    // State taken after the final iteration.
    state_t w_exit_state;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_exit_state = S_DONE;
`ifdef MDU_SIGNED_EN
        if (r_signed) begin
            w_exit_state = S_FIX;
        end
`endif
    end

    // The ALU operands follow the registered state directly. They do not
    // depend on alu_result_i, so there is no combinational loop through the
    // shared ALU.
    always_comb begin
        alu_src1_o = 32'd0;
        alu_src2_o = 32'd0;
        alu_ctrl_o = ALU_NOP;
        case (r_state)
            S_MUL: begin
                alu_src1_o = r_hi;
                alu_src2_o = r_lo[0] ? r_mcand : 32'd0;
                alu_ctrl_o = ALU_ADD;
            end
            S_DIV: begin
                alu_src1_o = w_div_src1;
                alu_src2_o = r_mcand;
                alu_ctrl_o = ALU_SUB;
            end
            default: begin
                alu_src1_o = 32'd0;
                alu_src2_o = 32'd0;
                alu_ctrl_o = ALU_NOP;
            end
        endcase
    end

    // Sequencer: state, datapath registers and registered status outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous and clears every register here, HI/LO
        // included, because software may read HI/LO straight after reset.
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_mcand   <= 32'd0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_div0    <= 1'b0;
            r_alu_req <= 1'b0;
`ifdef MDU_SIGNED_EN
            r_signed  <= 1'b0;
            r_is_div  <= 1'b0;
            r_neg_rs  <= 1'b0;
            r_neg_rt  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_lo      <= w_acc_rs;
                        r_hi      <= 32'd0;
                        r_mcand   <= w_acc_rt;
                        r_count   <= '0;
                        r_div0    <= op_i[0] && (rt_i == 32'd0);
                        r_busy    <= 1'b1;
                        r_alu_req <= 1'b1;
                        r_state   <= op_i[0] ? S_DIV : S_MUL;
`ifdef MDU_SIGNED_EN
                        r_signed  <= op_i[1];
                        r_is_div  <= op_i[0];
                        r_neg_rs  <= w_neg_rs;
                        r_neg_rt  <= w_neg_rt;
`endif
                    end
                end

                S_MUL: begin
                    // Shift the 65-bit {carry, sum, lo} right by one.
                    {r_hi, r_lo} <= {w_mul_carry, alu_result_i, r_lo[31:1]};
                    r_count      <= r_count + CNT_ONE;
                    if (r_count == CNT_LAST) begin
                        r_alu_req <= 1'b0;
                        r_state   <= w_exit_state;
                        r_done    <= (w_exit_state == S_DONE);
                    end
                end

                S_DIV: begin
                    r_hi    <= w_div_ge ? alu_result_i : w_div_src1;
                    r_lo    <= {r_lo[30:0], w_div_ge};
                    r_count <= r_count + CNT_ONE;
                    if (r_count == CNT_LAST) begin
                        r_alu_req <= 1'b0;
                        r_state   <= w_exit_state;
                        r_done    <= (w_exit_state == S_DONE);
                    end
                end

`ifdef MDU_SIGNED_EN
                S_FIX: begin
                    // The sign fix-up is done locally, because the block has
                    // already released the ALU.
                    if (r_is_div) begin
                        if (r_neg_rs ^ r_neg_rt) begin
                            r_lo <= 32'd0 - r_lo;
                        end
                        if (r_neg_rs) begin
                            r_hi <= 32'd0 - r_hi;
                        end
                    end else if (r_neg_rs ^ r_neg_rt) begin
                        {r_hi, r_lo} <= 64'd0 - {r_hi, r_lo};
                    end
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
`endif

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy    <= 1'b0;
                    r_alu_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_req_o = r_alu_req;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign div0_o    = r_div0;
    assign hi_o      = r_hi;
    assign lo_o      = r_lo;

endmodule
